// File: rtl/fm_wb_packer.sv
// Packs a PE row's write-back byte stream and guard stream into memory words,
// emitting full words as they complete and masked partial words on flush.
module fm_wb_lane_packer #(
    parameter int PACK   = 8,
    parameter int LANE_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_i,
    input  logic [ADDR_W-1:0]        base_i,
    input  logic                     run_i,
    input  logic                     flush_i,
    input  logic [LANE_W-1:0]        data_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     wr_ready_i,
    output logic                     wr_en_o,
    output logic [ADDR_W-1:0]        wr_addr_o,
    output logic [LANE_W*PACK-1:0]   wr_data_o,
    output logic [PACK-1:0]          wr_mask_o,
    output logic                     empty_o
);
    localparam int CNT_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int WORD_W = LANE_W * PACK;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PACK - 1);

    logic [CNT_W-1:0]  lane_cnt_q, lane_cnt_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic              hold_valid_q, hold_valid_d;
    logic [WORD_W-1:0] hold_data_q, hold_data_d;
    logic [PACK-1:0]   hold_mask_q, hold_mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [WORD_W-1:0] word_in;
    logic [PACK-1:0]   partial_mask;
    logic              accept;
    logic              hold_free;

    // word_in is the packing register with the offered element dropped into its lane
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
        assign word_in[gi*LANE_W +: LANE_W] =
            (lane_cnt_q == CNT_W'(gi)) ? data_i : pack_q[gi*LANE_W +: LANE_W];
        assign partial_mask[gi] = (CNT_W'(gi) < lane_cnt_q);
    end

    assign hold_free = !hold_valid_q || wr_ready_i;
    assign ready_o   = run_i && ((lane_cnt_q != LAST) || hold_free);
    assign accept    = valid_i && ready_o;
    assign empty_o   = (lane_cnt_q == '0) && !hold_valid_q;

    assign wr_en_o   = hold_valid_q;
    assign wr_addr_o = addr_q;
    assign wr_data_o = hold_data_q;
    assign wr_mask_o = hold_mask_q;

    always_comb begin
        lane_cnt_d   = lane_cnt_q;
        pack_d       = pack_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_mask_d  = hold_mask_q;
        addr_d       = addr_q;

        if (hold_valid_q && wr_ready_i) begin
            hold_valid_d = 1'b0;
            addr_d       = addr_q + ADDR_W'(1);
        end

        if (load_i) begin
            addr_d     = base_i;
            lane_cnt_d = '0;
            pack_d     = '0;
        end else if (accept) begin
            if (lane_cnt_q == LAST) begin
                hold_valid_d = 1'b1;
                hold_data_d  = word_in;
                hold_mask_d  = '1;
                lane_cnt_d   = '0;
                pack_d       = '0;
            end else begin
                pack_d     = word_in;
                lane_cnt_d = lane_cnt_q + CNT_W'(1);
            end
        end else if (flush_i && (lane_cnt_q != '0) && hold_free) begin
            // unfilled lanes are already zero because pack_q is cleared per word
            hold_valid_d = 1'b1;
            hold_data_d  = pack_q;
            hold_mask_d  = partial_mask;
            lane_cnt_d   = '0;
            pack_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt_q   <= '0;
            pack_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_mask_q  <= '0;
            addr_q       <= '0;
        end else begin
            lane_cnt_q   <= lane_cnt_d;
            pack_q       <= pack_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_mask_q  <= hold_mask_d;
            addr_q       <= addr_d;
        end
    end
endmodule

module fm_wb_packer #(
    parameter int PACK   = 8,
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    fm_base_i,
    input  logic [ADDR_W-1:0]    guard_base_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic [7:0]           wb_data_i,
    input  logic                 wb_valid_i,
    output logic                 wb_ready_o,
    input  logic [5:0]           guard_i,
    input  logic                 guard_valid_i,
    output logic                 guard_ready_o,
    input  logic                 wb_finish_i,
    output logic                 fm_wr_en_o,
    output logic [ADDR_W-1:0]    fm_wr_addr_o,
    output logic [8*PACK-1:0]    fm_wr_data_o,
    output logic [PACK-1:0]      fm_wr_mask_o,
    input  logic                 fm_wr_ready_i,
    output logic                 guard_wr_en_o,
    output logic [ADDR_W-1:0]    guard_wr_addr_o,
    output logic [6*PACK-1:0]    guard_wr_data_o,
    output logic [PACK-1:0]      guard_wr_mask_o,
    input  logic                 guard_wr_ready_i
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t state_q, state_d;
    logic   load;
    logic   fm_empty, guard_empty;

    assign load   = (state_q == S_IDLE) && start_i;
    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (wb_finish_i) state_d = S_FLUSH;
            S_FLUSH: if (fm_empty && guard_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    fm_wb_lane_packer #(.PACK(PACK), .LANE_W(8), .ADDR_W(ADDR_W)) u_fm (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .base_i     (fm_base_i),
        .run_i      (state_q == S_RUN),
        .flush_i    (state_q == S_FLUSH),
        .data_i     (wb_data_i),
        .valid_i    (wb_valid_i),
        .ready_o    (wb_ready_o),
        .wr_ready_i (fm_wr_ready_i),
        .wr_en_o    (fm_wr_en_o),
        .wr_addr_o  (fm_wr_addr_o),
        .wr_data_o  (fm_wr_data_o),
        .wr_mask_o  (fm_wr_mask_o),
        .empty_o    (fm_empty)
    );

    fm_wb_lane_packer #(.PACK(PACK), .LANE_W(6), .ADDR_W(ADDR_W)) u_guard (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load),
        .base_i     (guard_base_i),
        .run_i      (state_q == S_RUN),
        .flush_i    (state_q == S_FLUSH),
        .data_i     (guard_i),
        .valid_i    (guard_valid_i),
        .ready_o    (guard_ready_o),
        .wr_ready_i (guard_wr_ready_i),
        .wr_en_o    (guard_wr_en_o),
        .wr_addr_o  (guard_wr_addr_o),
        .wr_data_o  (guard_wr_data_o),
        .wr_mask_o  (guard_wr_mask_o),
        .empty_o    (guard_empty)
    );
endmodule

// File: tb/tb_fm_wb_packer.sv
// Directed bench for fm_wb_packer: write-back/guard packing, stalls, flush masks,
// address wrap and reset during flush.
module tb_fm_wb_packer;
    localparam int PACK   = 8;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic [ADDR_W-1:0] fm_base_i = '0, guard_base_i = '0;
    logic              busy_o, done_o;
    logic [7:0]        wb_data_i = '0;
    logic              wb_valid_i = 1'b0;
    logic              wb_ready_o;
    logic [5:0]        guard_i = '0;
    logic              guard_valid_i = 1'b0;
    logic              guard_ready_o;
    logic              wb_finish_i = 1'b0;
    logic              fm_wr_en_o;
    logic [ADDR_W-1:0] fm_wr_addr_o;
    logic [8*PACK-1:0] fm_wr_data_o;
    logic [PACK-1:0]   fm_wr_mask_o;
    logic              fm_wr_ready_i = 1'b1;
    logic              guard_wr_en_o;
    logic [ADDR_W-1:0] guard_wr_addr_o;
    logic [6*PACK-1:0] guard_wr_data_o;
    logic [PACK-1:0]   guard_wr_mask_o;
    logic              guard_wr_ready_i = 1'b1;

    fm_wb_packer #(.PACK(PACK), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .fm_base_i(fm_base_i), .guard_base_i(guard_base_i),
        .busy_o(busy_o), .done_o(done_o),
        .wb_data_i(wb_data_i), .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
        .guard_i(guard_i), .guard_valid_i(guard_valid_i), .guard_ready_o(guard_ready_o),
        .wb_finish_i(wb_finish_i),
        .fm_wr_en_o(fm_wr_en_o), .fm_wr_addr_o(fm_wr_addr_o), .fm_wr_data_o(fm_wr_data_o),
        .fm_wr_mask_o(fm_wr_mask_o), .fm_wr_ready_i(fm_wr_ready_i),
        .guard_wr_en_o(guard_wr_en_o), .guard_wr_addr_o(guard_wr_addr_o),
        .guard_wr_data_o(guard_wr_data_o), .guard_wr_mask_o(guard_wr_mask_o),
        .guard_wr_ready_i(guard_wr_ready_i)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int wb_acc = 0;
    int done_cnt = 0;
    int stall_cnt = 0;
    bit stall_mon = 1'b0;

    logic [ADDR_W-1:0] fa_q[$];
    logic [63:0]       fd_q[$];
    logic [7:0]        fmk_q[$];
    logic [ADDR_W-1:0] ga_q[$];
    logic [47:0]       gd_q[$];
    logic [7:0]        gmk_q[$];

    logic              prev_fm_stall = 1'b0, prev_g_stall = 1'b0;
    logic [ADDR_W-1:0] prev_fm_addr, prev_g_addr;
    logic [63:0]       prev_fm_data;
    logic [47:0]       prev_g_data;
    logic [7:0]        prev_fm_mask, prev_g_mask;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction log plus hold-stability and stall-condition checks, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            prev_fm_stall = 1'b0;
            prev_g_stall  = 1'b0;
        end else begin
            if (prev_fm_stall) begin
                check("fm_stall_stable", {45'd0, fm_wr_en_o, fm_wr_addr_o, fm_wr_mask_o},
                      {45'd0, 1'b1, prev_fm_addr, prev_fm_mask});
                check("fm_stall_data", fm_wr_data_o, prev_fm_data);
            end
            if (prev_g_stall) begin
                check("guard_stall_stable", {45'd0, guard_wr_en_o, guard_wr_addr_o, guard_wr_mask_o},
                      {45'd0, 1'b1, prev_g_addr, prev_g_mask});
                check("guard_stall_data", {16'd0, guard_wr_data_o}, {16'd0, prev_g_data});
            end
            if (fm_wr_en_o && fm_wr_ready_i) begin
                fa_q.push_back(fm_wr_addr_o);
                fd_q.push_back(fm_wr_data_o);
                fmk_q.push_back(fm_wr_mask_o);
                $display("[TB] fm write addr=%h data=%h mask=%h", fm_wr_addr_o, fm_wr_data_o, fm_wr_mask_o);
            end
            if (guard_wr_en_o && guard_wr_ready_i) begin
                ga_q.push_back(guard_wr_addr_o);
                gd_q.push_back(guard_wr_data_o);
                gmk_q.push_back(guard_wr_mask_o);
                $display("[TB] guard write addr=%h data=%h mask=%h", guard_wr_addr_o, guard_wr_data_o, guard_wr_mask_o);
            end
            if (stall_mon && wb_valid_i && !wb_ready_o) begin
                stall_cnt++;
                check("stall_cond", {61'd0, (wb_acc % 8 == 7), fm_wr_en_o, fm_wr_ready_i}, 64'd6);
            end
            if (wb_valid_i && wb_ready_o) wb_acc++;
            if (done_o) done_cnt++;
            prev_fm_stall = fm_wr_en_o && !fm_wr_ready_i;
            prev_fm_addr  = fm_wr_addr_o;
            prev_fm_data  = fm_wr_data_o;
            prev_fm_mask  = fm_wr_mask_o;
            prev_g_stall  = guard_wr_en_o && !guard_wr_ready_i;
            prev_g_addr   = guard_wr_addr_o;
            prev_g_data   = guard_wr_data_o;
            prev_g_mask   = guard_wr_mask_o;
        end
    end

    task automatic new_test();
        fa_q.delete(); fd_q.delete(); fmk_q.delete();
        ga_q.delete(); gd_q.delete(); gmk_q.delete();
        wb_acc = 0;
        done_cnt = 0;
    endtask

    task automatic start_run(input logic [ADDR_W-1:0] fb, input logic [ADDR_W-1:0] gb);
        fm_base_i = fb;
        guard_base_i = gb;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic finish_pulse();
        wb_finish_i = 1'b1;
        step();
        wb_finish_i = 1'b0;
    endtask

    task automatic send_wb(input int n, input logic [7:0] first, input bit fin_last);
        for (int i = 0; i < n; i++) begin
            int t;
            wb_data_i   = first + 8'(i);
            wb_valid_i  = 1'b1;
            wb_finish_i = fin_last && (i == n - 1);
            t = 0;
            @(negedge clk);
            while (!wb_ready_o && t < 200) begin
                t++;
                @(negedge clk);
            end
            if (t >= 200) check("wb_timeout", {63'd0, wb_ready_o}, 64'd1);
            step();
        end
        wb_valid_i  = 1'b0;
        wb_finish_i = 1'b0;
    endtask

    function automatic logic [5:0] gval(input int i);
        return 6'(i * 7 + 3);
    endfunction

    task automatic send_guard(input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            guard_i       = gval(i);
            guard_valid_i = 1'b1;
            t = 0;
            @(negedge clk);
            while (!guard_ready_o && t < 200) begin
                t++;
                @(negedge clk);
            end
            if (t >= 200) check("guard_timeout", {63'd0, guard_ready_o}, 64'd1);
            step();
        end
        guard_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        @(negedge clk);
        while (!done_o && t < 300) begin
            t++;
            @(negedge clk);
        end
        check({tag, "_done"}, {63'd0, done_o}, 64'd1);
        check({tag, "_drained_at_done"}, {62'd0, fm_wr_en_o, guard_wr_en_o}, 64'd0);
        step();
        repeat (3) step();
        check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, "_idle"}, {63'd0, busy_o}, 64'd0);
    endtask

    task automatic check_fm(input string tag, input int idx, input logic [ADDR_W-1:0] a,
                            input logic [63:0] d, input logic [7:0] m);
        check({tag, "_addr"}, 64'(fa_q[idx]), 64'(a));
        check({tag, "_data"}, fd_q[idx], d);
        check({tag, "_mask"}, 64'(fmk_q[idx]), 64'(m));
    endtask

    initial begin
        logic [47:0] gexp;

        // reset state
        repeat (3) step();
        check("rst_ctrl", {58'd0, busy_o, done_o, wb_ready_o, guard_ready_o, fm_wr_en_o, guard_wr_en_o}, 64'd0);
        check("rst_addr", {44'd0, fm_wr_addr_o, guard_wr_addr_o}, 64'd0);
        check("rst_fm_data", fm_wr_data_o, 64'd0);
        check("rst_guard_data", {16'd0, guard_wr_data_o}, 64'd0);
        check("rst_mask", {48'd0, fm_wr_mask_o, guard_wr_mask_o}, 64'd0);
        rst = 1'b0;
        step();

        // two full words back-to-back
        new_test();
        start_run(10'h010, 10'h200);
        check("t1_busy", {63'd0, busy_o}, 64'd1);
        send_wb(16, 8'h01, 1'b0);
        finish_pulse();
        wait_done("t1");
        check("t1_nwr", 64'(fa_q.size()), 64'd2);
        check_fm("t1_w0", 0, 10'h010, 64'h0807060504030201, 8'hFF);
        check_fm("t1_w1", 1, 10'h011, 64'h100F0E0D0C0B0A09, 8'hFF);
        check("t1_nguard", 64'(ga_q.size()), 64'd0);
        wb_valid_i = 1'b1;
        #1;
        check("t1_idle_not_ready", {63'd0, wb_ready_o}, 64'd0);
        wb_valid_i = 1'b0;
        step();

        // 11 bytes, finish coincides with the last byte
        new_test();
        start_run(10'h020, 10'h000);
        send_wb(11, 8'hA1, 1'b1);
        wait_done("t2");
        check("t2_nwr", 64'(fa_q.size()), 64'd2);
        check_fm("t2_w0", 0, 10'h020, 64'hA8A7A6A5A4A3A2A1, 8'hFF);
        check_fm("t2_w1", 1, 10'h021, 64'h0000000000ABAAA9, 8'h07);

        // write-port back-pressure: a 5-cycle dip, then a dip long enough to meet lane 7
        new_test();
        stall_cnt = 0;
        start_run(10'h030, 10'h000);
        stall_mon = 1'b1;
        fork
            send_wb(24, 8'h40, 1'b0);
            begin
                repeat (8) step();
                fm_wr_ready_i = 1'b0;
                repeat (5) step();
                fm_wr_ready_i = 1'b1;
                repeat (2) step();
                fm_wr_ready_i = 1'b0;
                repeat (10) step();
                fm_wr_ready_i = 1'b1;
            end
        join
        stall_mon = 1'b0;
        finish_pulse();
        wait_done("t3");
        check("t3_stall_seen", {63'd0, stall_cnt > 0}, 64'd1);
        check("t3_accepted", 64'(wb_acc), 64'd24);
        check("t3_nwr", 64'(fa_q.size()), 64'd3);
        check_fm("t3_w0", 0, 10'h030, 64'h4746454443424140, 8'hFF);
        check_fm("t3_w1", 1, 10'h031, 64'h4F4E4D4C4B4A4948, 8'hFF);
        check_fm("t3_w2", 2, 10'h032, 64'h5756555453525150, 8'hFF);

        // guard stream with random write-ready alongside a 3-byte partial
        new_test();
        start_run(10'h050, 10'h3F0);
        fork
            send_wb(3, 8'hC1, 1'b0);
            send_guard(8);
            begin
                repeat (30) begin
                    guard_wr_ready_i = 1'($urandom_range(0, 1));
                    step();
                end
                guard_wr_ready_i = 1'b1;
            end
        join
        finish_pulse();
        wait_done("t4");
        gexp = '0;
        for (int i = 0; i < 8; i++) gexp[i*6 +: 6] = gval(i);
        check("t4_nguard", 64'(ga_q.size()), 64'd1);
        check("t4_guard_addr", 64'(ga_q[0]), 64'h3F0);
        check("t4_guard_data", {16'd0, gd_q[0]}, {16'd0, gexp});
        check("t4_guard_mask", 64'(gmk_q[0]), 64'hFF);
        check("t4_nwr", 64'(fa_q.size()), 64'd1);
        check_fm("t4_w0", 0, 10'h050, 64'h0000000000C3C2C1, 8'h07);

        // address wrap at the top of the word space
        new_test();
        start_run(10'h3FF, 10'h000);
        send_wb(16, 8'h01, 1'b0);
        finish_pulse();
        wait_done("t5");
        check("t5_nwr", 64'(fa_q.size()), 64'd2);
        check_fm("t5_w0", 0, 10'h3FF, 64'h0807060504030201, 8'hFF);
        check_fm("t5_w1", 1, 10'h000, 64'h100F0E0D0C0B0A09, 8'hFF);

        // reset while a partial word is pending in FLUSH, then a clean run
        new_test();
        start_run(10'h060, 10'h000);
        send_wb(5, 8'hD0, 1'b0);
        fm_wr_ready_i = 1'b0;
        finish_pulse();
        check("t6_flush_busy", {63'd0, busy_o}, 64'd1);
        rst = 1'b1;
        step();
        check("t6_rst_ctrl", {58'd0, busy_o, done_o, wb_ready_o, guard_ready_o, fm_wr_en_o, guard_wr_en_o}, 64'd0);
        check("t6_rst_addr", {44'd0, fm_wr_addr_o, guard_wr_addr_o}, 64'd0);
        check("t6_rst_data", fm_wr_data_o, 64'd0);
        check("t6_rst_mask", {48'd0, fm_wr_mask_o, guard_wr_mask_o}, 64'd0);
        rst = 1'b0;
        fm_wr_ready_i = 1'b1;
        repeat (3) step();
        check("t6_no_write", 64'(fa_q.size()), 64'd0);
        start_run(10'h040, 10'h000);
        send_wb(8, 8'hE0, 1'b0);
        finish_pulse();
        wait_done("t6b");
        check("t6b_nwr", 64'(fa_q.size()), 64'd1);
        check_fm("t6b_w0", 0, 10'h040, 64'hE7E6E5E4E3E2E1E0, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fm_wb_packer.md
FM_WB_PACKER -- requirements
Module: fm_wb_packer

Interface
REQ-001 SHALL have parameter PACK, default 8, meaning write-back bytes / guard entries packed per memory word.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning memory word-address width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_i  input  1  begin a layer write-back; sampled in IDLE only.
REQ-006 SHALL have ports fm_base_i / guard_base_i  input  ADDR_W each  first word address of each region, latched on start.
REQ-007 SHALL have ports busy_o  output  1  (state != IDLE) and done_o  output  1  one-cycle completion pulse.
REQ-008 SHALL have ports wb_data_i  input  8, wb_valid_i  input  1, wb_ready_o  output  1  write-back byte stream from one PE row.
REQ-009 SHALL have ports guard_i  input  6, guard_valid_i  input  1, guard_ready_o  output  1  guard stream from the same row.
REQ-010 SHALL have port wb_finish_i  input  1  last element of both streams has been presented.
REQ-011 SHALL have ports fm_wr_en_o  output  1, fm_wr_addr_o  output  ADDR_W, fm_wr_data_o  output  8*PACK, fm_wr_mask_o  output  PACK, fm_wr_ready_i  input  1.
REQ-012 SHALL have ports guard_wr_en_o  output  1, guard_wr_addr_o  output  ADDR_W, guard_wr_data_o  output  6*PACK, guard_wr_mask_o  output  PACK, guard_wr_ready_i  input  1.

Function
REQ-013 SHALL implement states IDLE, RUN, FLUSH, DONE; IDLE->RUN on start_i, RUN->FLUSH on wb_finish_i, FLUSH->DONE when both partial packers are empty and both holding registers are drained, DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL, on start_i in IDLE, latch both base addresses, clear both lane counters, and clear both packing registers.
REQ-015 SHALL transfer a byte only on wb_valid_i && wb_ready_o, writing it into lane index lane_cnt (lane 0 = bits [7:0]), then incrementing lane_cnt.
REQ-016 SHALL drive wb_ready_o = RUN && (lane_cnt != PACK-1 || !fm_hold_valid || fm_wr_ready_i); this stalls only the byte completing a word while the previous word is not yet accepted.
REQ-017 SHALL, when lane PACK-1 is written, move the full word to the holding register with mask all-ones, assert fm_wr_en_o the next cycle, and reset lane_cnt to 0 in the same cycle.
REQ-018 SHALL hold fm_wr_en_o, address, data, and mask stable until fm_wr_en_o && fm_wr_ready_i, then increment the address by 1 modulo 2^ADDR_W.
REQ-019 SHALL apply REQ-015 to REQ-018 identically and independently to the guard stream (6-bit lanes, guard_* ports).
REQ-020 SHALL, when wb_finish_i coincides with an accepted byte or guard, accept that element before entering FLUSH; elements offered in FLUSH, DONE, or IDLE SHALL not be accepted (ready low).
REQ-021 SHALL, in FLUSH, emit each non-empty partial word once its holding register is free, with mask bit k = 1 only for filled lanes and unfilled lanes zero; an empty packer emits nothing.
REQ-022 SHALL ignore start_i outside IDLE and wb_finish_i outside RUN.
REQ-023 SHALL allow address wrap from 2^ADDR_W-1 to 0 without error or stall.

Reset
REQ-024 SHALL, with rst high at a clock edge, enter IDLE and drive busy_o, done_o, wb_ready_o, guard_ready_o, fm_wr_en_o, and guard_wr_en_o to 0; clear all addresses, data, masks, and lane counters to 0; and discard any pending word, including mid-RUN or mid-FLUSH.

Verification
REQ-025 SHALL cover: PACK=8, fm_base=0x010, 16 bytes 0x01..0x10 back-to-back, fm_wr_ready_i=1 -> writes at 0x010 data 0x0807..01 and 0x011 data 0x100F..09, both mask 0xFF, then done_o a single pulse.
REQ-026 SHALL cover: 11 bytes then wb_finish_i -> one full word, then a partial word at base+1 with mask 0x07, upper 5 lanes zero.
REQ-027 SHALL cover: fm_wr_ready_i held low for 5 cycles during a 24-byte stream -> wb_ready_o low only when offering lane 7 with the holding register full, no byte lost or duplicated, and stable outputs during the stall.
REQ-028 SHALL cover: guard stream of 8 entries with guard_wr_ready_i random, alongside 3 bytes -> one guard word mask 0xFF, one fm word mask 0x07, and done_o only after both are drained.
REQ-029 SHALL cover: fm_base=2^ADDR_W-1 with 16 bytes -> writes at addresses 1023 then 0.
REQ-030 SHALL cover: rst asserted in FLUSH with a pending partial word -> no write issued, all outputs 0 next cycle, and a subsequent start runs cleanly.
